// File: rtl/mo_mul_pkg.sv
// Shared constants and slot layout for the radix-2 Montgomery multiplier pipeline.
// Q = Q_K * 2^Q_M + 1 for the two supported lattice moduli.
package mo_mul_pkg;

  localparam int unsigned KYBER_Q_M     = 8;
  localparam int unsigned KYBER_Q_K     = 13;
  localparam int unsigned KYBER_Q       = 3329;
  localparam int unsigned DILITHIUM_Q_M = 13;
  localparam int unsigned DILITHIUM_Q_K = 1023;
  localparam int unsigned DILITHIUM_Q   = 8380417;

  // Slot fields are sized for the widest supported build (DATA_W + 2 <= SLOT_W);
  // unused upper bits are tied to zero and trimmed by synthesis.
  localparam int unsigned SLOT_W     = 32;
  localparam int unsigned SLOT_TAG_W = 32;

  typedef struct packed {
    logic                  valid;
    logic [SLOT_TAG_W-1:0] tag;
    logic [SLOT_W-1:0]     a;
    logic [SLOT_W-1:0]     b;
    logic [SLOT_W-1:0]     t;
  } mo_slot_t;

  function automatic int unsigned mo_q(input int unsigned k, input int unsigned m);
    return k * (32'd1 << m) + 32'd1;
  endfunction

endpackage

// File: rtl/mo_mul_stage.sv
// One radix-2 Montgomery step: t = (t + b_bit*a [+ Q if odd]) / 2.
// Purely combinational; keeps t < 2Q when a < Q and t_in < 2Q.
module mo_mul_stage
  import mo_mul_pkg::*;
#(
  parameter int unsigned DATA_W = 23,
  parameter int unsigned Q_M    = 13,
  parameter int unsigned Q_K    = 1023
) (
  input  logic [DATA_W-1:0] a,
  input  logic              b_bit,
  input  logic [DATA_W+1:0] t_in,
  output logic [DATA_W+1:0] t_out
);

  localparam logic [DATA_W+2:0] Q_VAL = (DATA_W + 3)'(mo_q(Q_K, Q_M));

  logic [DATA_W+2:0] sum_a;
  logic [DATA_W+2:0] sum_q;
  logic              unused_lsb;

  always_comb begin
    sum_a = {1'b0, t_in} + (b_bit ? {3'b000, a} : '0);
    sum_q = sum_a + (sum_a[0] ? Q_VAL : '0);
    t_out = sum_q[DATA_W+2:1];
  end

  // The sum is even by construction, so the dropped bit is always zero.
  assign unused_lsb = sum_q[0];

endmodule

// File: rtl/mo_mul_pipe.sv
// Fully pipelined Montgomery multiplier: out = a*b*2^-DATA_W mod Q, one op per cycle.
// Define MO_MUL_FINAL_REDUCE_EN to add a correction slot that brings the result into [0,Q).
module mo_mul_pipe
  import mo_mul_pkg::*;
#(
  parameter int unsigned DATA_W = 23,
  parameter int unsigned Q_M    = DILITHIUM_Q_M,
  parameter int unsigned Q_K    = DILITHIUM_Q_K,
  parameter int unsigned TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   out_data,
  output logic [TAG_W-1:0]  out_tag
);

`ifdef MO_MUL_FINAL_REDUCE_EN
  localparam int unsigned NUM_SLOTS = DATA_W + 1;
  localparam logic [DATA_W+1:0] Q_VAL = (DATA_W + 2)'(mo_q(Q_K, Q_M));
  logic [DATA_W+1:0] t_fin;
`else
  localparam int unsigned NUM_SLOTS = DATA_W;
`endif

  mo_slot_t          slot_q [NUM_SLOTS];
  mo_slot_t          slot_d [NUM_SLOTS];
  mo_slot_t          src    [DATA_W];
  logic [DATA_W+1:0] t_nxt  [DATA_W];
  logic              stall;
  logic              unused_slot_bits;

  assign stall    = slot_q[NUM_SLOTS-1].valid && !out_ready;
  assign in_ready = !stall;

  // Stage i reads the new operation (i == 0) or the previous slot.
  always_comb begin
    src[0]       = '0;
    src[0].valid = in_valid;
    src[0].tag   = SLOT_TAG_W'(in_tag);
    src[0].a     = SLOT_W'(a);
    src[0].b     = SLOT_W'(b);
    for (int i = 1; i < DATA_W; i++) begin
      src[i] = slot_q[i-1];
    end
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_stage
    mo_mul_stage #(
      .DATA_W (DATA_W),
      .Q_M    (Q_M),
      .Q_K    (Q_K)
    ) u_stage (
      .a     (src[i].a[DATA_W-1:0]),
      .b_bit (src[i].b[i]),
      .t_in  (src[i].t[DATA_W+1:0]),
      .t_out (t_nxt[i])
    );
  end

  always_comb begin
    for (int i = 0; i < DATA_W; i++) begin
      slot_d[i]   = src[i];
      slot_d[i].t = SLOT_W'(t_nxt[i]);
    end
`ifdef MO_MUL_FINAL_REDUCE_EN
    t_fin = slot_q[DATA_W-1].t[DATA_W+1:0];
    if (t_fin >= Q_VAL) begin
      t_fin = t_fin - Q_VAL;
    end
    slot_d[DATA_W]   = slot_q[DATA_W-1];
    slot_d[DATA_W].t = SLOT_W'(t_fin);
`endif
  end

  // A stall at the output freezes every slot so nothing is lost or duplicated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= '0;
      end
    end else if (!stall) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign out_valid = slot_q[NUM_SLOTS-1].valid;
  assign out_data  = slot_q[NUM_SLOTS-1].t[DATA_W:0];
  assign out_tag   = slot_q[NUM_SLOTS-1].tag[TAG_W-1:0];

  always_comb begin
    unused_slot_bits = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      unused_slot_bits = unused_slot_bits ^ (^slot_q[i]);
    end
  end

endmodule

// File: tb/tb_mo_mul_pipe.sv
// Directed bench for mo_mul_pipe: Dilithium-default instance plus a 12-bit Kyber instance.
module tb_mo_mul_pipe;
  import mo_mul_pkg::*;

  localparam int unsigned DW  = 23;
  localparam int unsigned KDW = 12;
  localparam longint unsigned QD = DILITHIUM_Q;
  localparam longint unsigned QK = KYBER_Q;
`ifdef MO_MUL_FINAL_REDUCE_EN
  localparam int LAT   = DW + 1;
  localparam int LAT_K = KDW + 1;
  localparam bit REDUCE = 1'b1;
`else
  localparam int LAT   = DW;
  localparam int LAT_K = KDW;
  localparam bit REDUCE = 1'b0;
`endif

  logic          clk, rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] a, b;
  logic [7:0]    in_tag, out_tag;
  logic [DW:0]   out_data;
  logic           k_in_valid, k_in_ready, k_out_valid, k_out_ready;
  logic [KDW-1:0] k_a, k_b;
  logic [7:0]     k_in_tag, k_out_tag;
  logic [KDW:0]   k_out_data;

  int nvec, nerr;

  mo_mul_pipe #(.DATA_W(DW), .Q_M(DILITHIUM_Q_M), .Q_K(DILITHIUM_Q_K), .TAG_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag)
  );

  mo_mul_pipe #(.DATA_W(KDW), .Q_M(KYBER_Q_M), .Q_K(KYBER_Q_K), .TAG_W(8)) u_dut_k (
    .clk(clk), .rst_n(rst_n), .in_valid(k_in_valid), .in_ready(k_in_ready), .a(k_a), .b(k_b),
    .in_tag(k_in_tag), .out_valid(k_out_valid), .out_ready(k_out_ready), .out_data(k_out_data),
    .out_tag(k_out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference radix-2 Montgomery reduction, independent integer arithmetic.
  function automatic longint unsigned model(input longint unsigned x, input longint unsigned y,
                                            input int dw, input longint unsigned q);
    longint unsigned t;
    t = 0;
    for (int i = 0; i < dw; i++) begin
      if (((y >> i) & 1) == 1) t = t + x;
      if ((t & 1) == 1) t = t + q;
      t = t >> 1;
    end
    if (REDUCE && t >= q) t = t - q;
    return t;
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    nvec += 5;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    if (out_data !== '0) begin nerr++; $display("FAIL rst_out_data got %0d want 0", out_data); end
    if (out_tag !== 8'h00) begin nerr++; $display("FAIL rst_out_tag got %0h want 0", out_tag); end
    if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
    if (k_out_valid !== 1'b0) begin nerr++; $display("FAIL rst_k_valid got %0b want 0", k_out_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int lat;
    longint unsigned exp;
    @(negedge clk);
    in_valid = 1'b1; a = 23'd8191; b = 23'd1; in_tag = 8'h5A;
    exp = model(8191, 1, DW, QD);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
    nvec += 4;
    if (lat != LAT) begin nerr++; $display("FAIL single_latency got %0d want %0d", lat, LAT); end
    if (64'(out_data) !== exp) begin nerr++; $display("FAIL single_data got %0d want %0d", out_data, exp); end
    if ((64'(out_data) % QD) !== 64'd1) begin nerr++; $display("FAIL single_modq got %0d want 1", out_data); end
    if (out_tag !== 8'h5A) begin nerr++; $display("FAIL single_tag got %0h want 5a", out_tag); end
    @(negedge clk);
    nvec++;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL single_drop got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    longint unsigned va [3];
    longint unsigned vb [3];
    longint unsigned vm [3];
    int got;
    bit want;
    va = '{8191, 8380416, 0};
    vb = '{8191, 8191, 12345};
    vm = '{8191, 8380416, 0};
    got = 0;
    for (int c = 0; c < LAT + 6; c++) begin
      @(negedge clk);
      want = (c >= LAT && c < LAT + 3);
      nvec++;
      if (out_valid !== want) begin nerr++; $display("FAIL b2b_valid c=%0d got %0b want %0b", c, out_valid, want); end
      if (out_valid === 1'b1 && got < 3) begin
        nvec += 3;
        if (64'(out_data) !== model(va[got], vb[got], DW, QD)) begin
          nerr++; $display("FAIL b2b_data op%0d got %0d want %0d", got, out_data, model(va[got], vb[got], DW, QD));
        end
        if ((64'(out_data) % QD) !== vm[got]) begin
          nerr++; $display("FAIL b2b_modq op%0d got %0d want %0d", got, out_data, vm[got]);
        end
        if (out_tag !== 8'(8'h10 + got)) begin
          nerr++; $display("FAIL b2b_tag op%0d got %0h want %0h", got, out_tag, 8'h10 + got);
        end
        got++;
      end
      if (c < 3) begin
        in_valid = 1'b1; a = DW'(va[c]); b = DW'(vb[c]); in_tag = 8'(8'h10 + c);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_stall();
    logic [DW:0] hold;
    hold = '0;
    for (int c = 0; c < 2 * LAT + 10; c++) begin
      @(negedge clk);
      if (c < 3) begin
        in_valid = 1'b1; a = DW'(c + 1); b = 23'd8191; in_tag = 8'(8'h21 + c);
      end else if (c == LAT) begin
        nvec += 3;
        if (out_valid !== 1'b1) begin nerr++; $display("FAIL stall_first_valid got %0b want 1", out_valid); end
        if (out_tag !== 8'h21) begin nerr++; $display("FAIL stall_first_tag got %0h want 21", out_tag); end
        if (64'(out_data) !== model(1, 8191, DW, QD)) begin
          nerr++; $display("FAIL stall_first_data got %0d want %0d", out_data, model(1, 8191, DW, QD));
        end
        hold = out_data;
        out_ready = 1'b0;
        in_valid = 1'b1; a = 23'd5; b = 23'd5; in_tag = 8'h77;
        #1;
        nvec++;
        if (in_ready !== 1'b0) begin nerr++; $display("FAIL stall_in_ready got %0b want 0", in_ready); end
      end else if (c > LAT && c <= LAT + 5) begin
        nvec += 4;
        if (in_ready !== 1'b0) begin nerr++; $display("FAIL stall_hold_ready c=%0d got %0b want 0", c, in_ready); end
        if (out_valid !== 1'b1) begin nerr++; $display("FAIL stall_hold_valid c=%0d got %0b want 1", c, out_valid); end
        if (out_tag !== 8'h21) begin nerr++; $display("FAIL stall_hold_tag c=%0d got %0h want 21", c, out_tag); end
        if (out_data !== hold) begin nerr++; $display("FAIL stall_hold_data c=%0d got %0d want %0d", c, out_data, hold); end
        if (c == LAT + 5) begin out_ready = 1'b1; in_valid = 1'b0; end
      end else if (c == LAT + 6 || c == LAT + 7) begin
        nvec += 3;
        if (out_valid !== 1'b1) begin nerr++; $display("FAIL stall_rel_valid c=%0d got %0b want 1", c, out_valid); end
        if (out_tag !== 8'(8'h22 + c - LAT - 6)) begin
          nerr++; $display("FAIL stall_rel_tag c=%0d got %0h want %0h", c, out_tag, 8'h22 + c - LAT - 6);
        end
        if (64'(out_data) !== model(longint'(c - LAT - 4), 8191, DW, QD)) begin
          nerr++; $display("FAIL stall_rel_data c=%0d got %0d want %0d", c, out_data, model(longint'(c - LAT - 4), 8191, DW, QD));
        end
      end else begin
        in_valid = 1'b0;
        nvec++;
        if (out_valid !== 1'b0) begin nerr++; $display("FAIL stall_idle c=%0d got %0b want 0", c, out_valid); end
      end
    end
  endtask

  task automatic test_reset_flight();
    int lat;
    for (int c = 0; c <= LAT + 2; c++) begin
      @(negedge clk);
      if (c < 10) begin
        in_valid = 1'b1; a = DW'(c + 1); b = 23'd8191; in_tag = 8'(8'h40 + c);
      end else begin
        in_valid = 1'b0;
      end
      if (c == LAT) begin
        nvec++;
        if (out_valid !== 1'b1) begin nerr++; $display("FAIL flight_pending got %0b want 1", out_valid); end
        out_ready = 1'b0;
      end
    end
    rst_n = 1'b0;
    #1;
    nvec += 4;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL flight_rst_valid got %0b want 0", out_valid); end
    if (out_data !== '0) begin nerr++; $display("FAIL flight_rst_data got %0d want 0", out_data); end
    if (out_tag !== 8'h00) begin nerr++; $display("FAIL flight_rst_tag got %0h want 0", out_tag); end
    if (in_ready !== 1'b1) begin nerr++; $display("FAIL flight_rst_ready got %0b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 2 * LAT + 4; c++) begin
      @(negedge clk);
      nvec++;
      if (out_valid !== 1'b0) begin nerr++; $display("FAIL flight_ghost c=%0d got %0b want 0", c, out_valid); end
    end
    in_valid = 1'b1; a = 23'd7; b = 23'd8191; in_tag = 8'h99;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
    nvec += 3;
    if (lat != LAT) begin nerr++; $display("FAIL flight_relat got %0d want %0d", lat, LAT); end
    if ((64'(out_data) % QD) !== 64'd7) begin nerr++; $display("FAIL flight_redata got %0d want 7 mod Q", out_data); end
    if (out_tag !== 8'h99) begin nerr++; $display("FAIL flight_retag got %0h want 99", out_tag); end
    @(negedge clk);
  endtask

  task automatic test_kyber();
    int lat, sent, recv, cyc;
    longint unsigned rinv, ea, eb, bound;
    longint unsigned exp_q [$];
    longint unsigned mod_q [$];
    logic [7:0]      tag_q [$];
    longint unsigned e, m;
    logic [7:0]      t;
    rinv = 0;
    for (longint unsigned x = 1; x < QK; x++) if (((767 * x) % QK) == 1) rinv = x;
    bound = REDUCE ? QK : 2 * QK;
    @(negedge clk);
    k_in_valid = 1'b1; k_a = 12'd767; k_b = 12'd1; k_in_tag = 8'h3C;
    @(negedge clk);
    k_in_valid = 1'b0;
    lat = 1;
    while (k_out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    nvec += 4;
    if (lat != LAT_K) begin nerr++; $display("FAIL kyber_latency got %0d want %0d", lat, LAT_K); end
    if (64'(k_out_data) !== model(767, 1, KDW, QK)) begin
      nerr++; $display("FAIL kyber_data got %0d want %0d", k_out_data, model(767, 1, KDW, QK));
    end
    if ((64'(k_out_data) % QK) !== 64'd1) begin nerr++; $display("FAIL kyber_modq got %0d want 1", k_out_data); end
    if (k_out_tag !== 8'h3C) begin nerr++; $display("FAIL kyber_tag got %0h want 3c", k_out_tag); end
    sent = 0; recv = 0; cyc = 0;
    while (recv < 10000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      k_out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 10000 && $urandom_range(0, 7) != 0) begin
        k_in_valid = 1'b1;
        k_a = 12'($urandom_range(0, 3328)); k_b = 12'($urandom_range(0, 3328));
        k_in_tag = sent[7:0];
      end else begin
        k_in_valid = 1'b0;
      end
      #1;
      if (k_out_valid === 1'b1 && k_out_ready) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++; $display("FAIL kyber_rand_extra got tag %0h want none", k_out_tag);
        end else begin
          e = exp_q.pop_front(); m = mod_q.pop_front(); t = tag_q.pop_front();
          nvec += 3;
          if (64'(k_out_data) !== e) begin nerr++; $display("FAIL kyber_rand_data got %0d want %0d", k_out_data, e); end
          if (k_out_tag !== t) begin nerr++; $display("FAIL kyber_rand_tag got %0h want %0h", k_out_tag, t); end
          if (64'(k_out_data) >= bound || (64'(k_out_data) % QK) !== m) begin
            nerr++; $display("FAIL kyber_rand_range got %0d want %0d mod Q below %0d", k_out_data, m, bound);
          end
        end
        recv++;
      end
      if (k_in_valid && k_in_ready === 1'b1) begin
        ea = 64'(k_a); eb = 64'(k_b);
        exp_q.push_back(model(ea, eb, KDW, QK));
        mod_q.push_back((((ea * eb) % QK) * rinv) % QK);
        tag_q.push_back(k_in_tag);
        sent++;
      end
    end
    k_in_valid = 1'b0; k_out_ready = 1'b1;
    nvec++;
    if (recv != 10000) begin nerr++; $display("FAIL kyber_rand_count got %0d want 10000", recv); end
  endtask

  initial begin
    nvec = 0; nerr = 0;
    in_valid = 1'b0; a = '0; b = '0; in_tag = '0; out_ready = 1'b1;
    k_in_valid = 1'b0; k_a = '0; k_b = '0; k_in_tag = '0; k_out_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_flight();
    test_kyber();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mo_mul_pipe.md
MO_MUL_PIPE -- requirements
Module: mo_mul_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 23, giving operand/result width and radix-2 stage count (2^DATA_W > Q).
REQ-002 SHALL have parameter Q_M, default 13, the power-of-two exponent in Q = Q_K*2^Q_M+1.
REQ-003 SHALL have parameter Q_K, default 1023, the odd factor in Q (defaults give Q=8380417; Q_M=8, Q_K=13 gives 3329).
REQ-004 SHALL have parameter TAG_W, default 8, the width of the sideband tag carried alongside each operation.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  a, b, in_tag valid this cycle.
REQ-008 in_ready  output  1  operation accepted when in_valid && in_ready.
REQ-009 a, b  input  DATA_W  unsigned operands, contract a<Q, b<Q.
REQ-010 in_tag  input  TAG_W  opaque sideband.
REQ-011 out_valid  output  1  out_data/out_tag valid.
REQ-012 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-013 out_data  output  DATA_W+1  result.
REQ-014 out_tag  output  TAG_W  in_tag of the same operation.

Function
REQ-015 SHALL compute out_data = a*b*2^-DATA_W mod Q via DATA_W radix-2 Montgomery stages, each stage: t += b[i]?a:0; if t odd t += Q; t >>= 1; intermediate width DATA_W+2, t<2Q invariant.
REQ-016 SHALL register one stage per pipeline slot plus, when REQ-024 applies, one correction slot: latency L = DATA_W+1 cycles from accept to out_valid with out_ready held high.
REQ-017 SHALL accept one operation per cycle at full throughput; each slot carries a valid bit, tag, a, b and partial t.
REQ-018 SHALL stall the entire pipeline (all slots hold) when out_valid && !out_ready; in_ready = !(out_valid && !out_ready), combinational.
REQ-019 SHALL advance bubbles (valid=0 slots) normally when not stalled; no bubble collapsing.
REQ-020 SHALL hold out_data/out_tag stable while out_valid && !out_ready.
REQ-021 in_valid during stall: not accepted, no state change; operands outside contract give unspecified data but correct valid/tag timing.

Reset
REQ-022 SHALL, on rst_n low, asynchronously clear all slot valid bits, out_valid=0, out_data=0, out_tag=0; in_ready=1 once out_valid=0.
REQ-023 Reset mid-operation SHALL discard all in-flight operations; first accept after release yields out_valid exactly L cycles later.

Configuration
REQ-024 With MO_MUL_FINAL_REDUCE_EN defined: correction slot subtracts Q if t>=Q, out_data in [0,Q), L=DATA_W+1.
REQ-025 Without MO_MUL_FINAL_REDUCE_EN: no correction slot, out_data = raw t in [0,2Q), L=DATA_W; handshake rules unchanged.

Structure
REQ-026 Package mo_mul_pkg SHALL hold Q_M/Q_K/Q constants for Kyber (8,13,3329) and Dilithium (13,1023,8380417) and a slot-state struct typedef.
REQ-027 One radix-2 step SHALL be sub-module mo_mul_stage (combinational, parameterised by DATA_W, Q_M, Q_K), instantiated DATA_W times via generate.

Verification (defaults, macro defined unless noted)
REQ-028 a=8191 (2^23 mod Q), b=1, tag=0x5A -> out_data=1, out_tag=0x5A at cycle 24.
REQ-029 Back-to-back: a=8191,b=8191 then a=8380416,b=8191 then a=0,b=12345 -> 8191, 8380416, 0 on three consecutive cycles.
REQ-030 out_ready low 5 cycles with output pending -> in_ready=0, outputs frozen, no loss/duplication after release.
REQ-031 rst_n pulsed low with 10 ops in flight -> out_valid=0, out_data=0 immediately; none emerge later.
REQ-032 Macro undefined, Q_M=8, Q_K=13, DATA_W=12: a=2^12 mod 3329=767, b=1 -> out_data=1 at cycle 12; 10^4 random a,b<3329 -> matches model, out_data<6658.
